xm_bus_master: RTL and testbench

Wishbone bus master that converts the multi-cycle core's byte-addressed load/store requests into single Wishbone classic cycles to the 16-bit word-addressed memory slave. It sits directly upstream of the memory: it generates the lane selects, aligns read data, flags misaligned accesses and hides the ack handshake behind a one-shot `done_o`. It owns the bus between the core and the memory, with no arbitration.

---
 rtl/xm_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_xm_bus_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xm_bus_master.sv
// Wishbone classic master: turns byte-addressed core loads/stores into single 16-bit word cycles.
// Optional ack timeout is compiled in with `define XM_BUS_TIMEOUT_EN.
module xm_bus_master #(
    parameter int WORD    = 16,
    parameter int ADDR    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic            byte_i,
    input  logic [ADDR-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [WORD-1:0] rdata_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [1:0]      sel_o,
    output logic [ADDR-2:0] adr_o,
    output logic [WORD-1:0] dat_o,
    input  logic [WORD-1:0] dat_i,
    input  logic            ack_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic            byte_q, byte_d;
    logic            lane_q, lane_d;
    logic [1:0]      sel_q, sel_d;
    logic [ADDR-2:0] adr_q, adr_d;
    logic [WORD-1:0] dat_q, dat_d;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rd_byte;
    logic            timeout_hit;

`ifdef XM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is held at zero outside BUS, so it is clear on every BUS entry.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != BUS) begin
            tmo_cnt_d = '0;
        end else if (!ack_i) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) && !ack_i;
`else
    assign timeout_hit = 1'b0;
`endif

    assign rd_byte = lane_q ? dat_i[15:8] : dat_i[7:0];

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        byte_d  = byte_q;
        lane_d  = lane_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d   = we_i;
                    byte_d = byte_i;
                    lane_d = addr_i[0];
                    if (!byte_i && addr_i[0]) begin
                        state_d = RECOVER;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        adr_d   = addr_i[ADDR-1:1];
                        if (byte_i) begin
                            sel_d = addr_i[0] ? 2'b10 : 2'b01;
                            dat_d = {wdata_i[7:0], wdata_i[7:0]};
                        end else begin
                            sel_d = 2'b11;
                            dat_d = wdata_i;
                        end
                    end
                end
            end

            BUS: begin
                // An ack in the same cycle as timeout expiry completes normally.
                if (ack_i) begin
                    state_d = RECOVER;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = byte_q ? {8'h00, rd_byte} : dat_i;
                    end
                end else if (timeout_hit) begin
                    state_d = RECOVER;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= 1'b0;
            sel_q   <= 2'b00;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;

endmodule

// File: tb/tb_xm_bus_master.sv
// Testbench for xm_bus_master: byte-array reference model, selectable falling/rising-edge slave.
module tb_xm_bus_master;

    localparam int WORD = 16;
    localparam int ADDR = 16;
`ifdef XM_BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 15;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_i = 1'b0;
    logic            we_i = 1'b0;
    logic            byte_i = 1'b0;
    logic [ADDR-1:0] addr_i = '0;
    logic [WORD-1:0] wdata_i = '0;
    logic            busy_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [WORD-1:0] rdata_o, dat_o, dat_i;
    logic [1:0]      sel_o;
    logic [ADDR-2:0] adr_o;
    logic            ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic       slave_rise = 1'b0;
    logic       ack_en     = 1'b1;
    logic       ack_rise   = 1'b0;
    logic       ack_fall   = 1'b0;
    logic [15:0] slv_mem [0:255];
    logic [7:0]  ref_mem [0:511];

    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] cur_exp;
    logic        cur_we, cur_byt, cur_mis;
    logic [15:0] cur_addr, cur_wdata;

    always #5 clk_i = ~clk_i;

    xm_bus_master #(
        .WORD    (WORD),
        .ADDR    (ADDR),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .byte_i  (byte_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .sel_o   (sel_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 311) ^ 16'hA5C3);
    endfunction

    // Slave memory: 256 words, aliased on the low 8 word-address bits.
    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = init_word(i);
    end

    assign dat_i = slv_mem[adr_o[7:0]];
    assign ack_i = slave_rise ? ack_rise : ack_fall;

    always @(negedge clk_i) ack_fall <= !slave_rise && ack_en && cyc_o && stb_o && !ack_fall;
    always @(posedge clk_i) ack_rise <= slave_rise && ack_en && cyc_o && stb_o && !ack_rise;

    always @(posedge clk_i) begin
        if (ack_i && cyc_o && stb_o && we_o) begin
            if (sel_o[0]) slv_mem[adr_o[7:0]][7:0]  <= dat_o[7:0];
            if (sel_o[1]) slv_mem[adr_o[7:0]][15:8] <= dat_o[15:8];
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive request fields and compute the expected load result from the byte model.
    task automatic driveFields(input logic we, input logic byt, input logic [15:0] addr, input logic [15:0] wdata);
        cur_we    = we;
        cur_byt   = byt;
        cur_addr  = addr;
        cur_wdata = wdata;
        cur_mis   = !byt && addr[0];
        if (!we && !cur_mis)
            cur_exp = byt ? {8'h00, ref_mem[addr[8:0]]}
                          : {ref_mem[{addr[8:1], 1'b1}], ref_mem[{addr[8:1], 1'b0}]};
        else
            cur_exp = exp_rdata;
        we_i    = we;
        byte_i  = byt;
        addr_i  = addr;
        wdata_i = wdata;
    endtask

    task automatic commitModel();
        exp_rdata = cur_exp;
        if (cur_we && !cur_mis) begin
            if (cur_byt) begin
                ref_mem[cur_addr[8:0]] = cur_wdata[7:0];
            end else begin
                ref_mem[{cur_addr[8:1], 1'b0}] = cur_wdata[7:0];
                ref_mem[{cur_addr[8:1], 1'b1}] = cur_wdata[15:8];
            end
        end
    endtask

    // One pulsed request, called at a falling edge with the master idle.
    task automatic applyStimulus(input logic we, input logic byt, input logic [15:0] addr, input logic [15:0] wdata);
        int lat;
        logic [1:0]  exp_sel;
        logic [15:0] exp_dat;
        driveFields(we, byt, addr, wdata);
        exp_sel = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        exp_dat = byt ? {wdata[7:0], wdata[7:0]} : wdata;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        if (cur_mis) begin
            checkOutput("mis_cyc", cyc_o, 0);
            checkOutput("mis_done", done_o, 1);
            checkOutput("mis_err", err_o, 1);
            checkOutput("mis_busy", busy_o, 1);
        end else begin
            checkOutput("bus_cyc", cyc_o, 1);
            checkOutput("bus_stb", stb_o, 1);
            checkOutput("bus_we", we_o, we);
            checkOutput("bus_sel", sel_o, exp_sel);
            checkOutput("bus_adr", adr_o, addr[15:1]);
            if (we) checkOutput("bus_dat", dat_o, exp_dat);
            checkOutput("bus_done_early", done_o, 0);
            lat = 0;
            while (!done_o && lat < 40) begin
                @(negedge clk_i);
                lat++;
            end
            checkOutput("done_latency", 32'(lat), slave_rise ? 2 : 1);
            checkOutput("done_err", err_o, 0);
            checkOutput("done_cyc", cyc_o, 0);
            checkOutput("done_busy", busy_o, 1);
        end
        checkOutput("rdata", rdata_o, cur_exp);
        commitModel();
        @(negedge clk_i);
        checkOutput("done_oneshot", done_o, 0);
        checkOutput("err_oneshot", err_o, 0);
        checkOutput("idle_busy", busy_o, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic        rw, rb;
        logic [15:0] ra;
        int          n, low, hi, dn;

        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            ref_mem[2*i]   = w[7:0];
            ref_mem[2*i+1] = w[15:8];
        end

        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_cyc", cyc_o, 0);
        checkOutput("rst_stb", stb_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_we", we_o, 0);
        checkOutput("rst_sel", sel_o, 0);
        checkOutput("rst_adr", adr_o, 0);
        checkOutput("rst_dat", dat_o, 0);
        checkOutput("rst_rdata", rdata_o, 0);
        rst_i = 1'b0;

        $display("[TB] directed accesses, falling-edge slave");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("dir_word_load", rdata_o, 16'hBEEF);
        applyStimulus(1'b1, 1'b1, 16'h0011, 16'h005A);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("dir_merge_load", rdata_o, 16'h5AEF);
        applyStimulus(1'b0, 1'b1, 16'h0011, 16'h0000);
        checkOutput("dir_byte_load", rdata_o, 16'h005A);
        applyStimulus(1'b0, 1'b0, 16'h0013, 16'h0000);
        checkOutput("dir_mis_keep", rdata_o, 16'h005A);

        $display("[TB] random accesses, falling-edge slave");
        for (int k = 0; k < 40; k++)
            applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

        $display("[TB] random accesses, rising-edge slave");
        slave_rise = 1'b1;
        for (int k = 0; k < 12; k++)
            applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

        $display("[TB] request held high, rising-edge slave");
        rb = 1'($urandom);
        ra = 16'($urandom);
        driveFields(1'($urandom), rb, rb ? ra : {ra[15:1], 1'b0}, 16'($urandom));
        req_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            low = 0;
            do begin
                @(negedge clk_i);
                n++;
                if (!cyc_o) low++;
            end while (!done_o && n < 40);
            checkOutput("held_spacing", 32'(n), (k == 0) ? 3 : 4);
            checkOutput("held_cyc_low", 32'(low), (k == 0) ? 1 : 2);
            checkOutput("held_err", err_o, 0);
            checkOutput("held_rdata", rdata_o, cur_exp);
            commitModel();
            if (k < 5) begin
                rw = 1'($urandom);
                rb = 1'($urandom);
                ra = 16'($urandom);
                driveFields(rw, rb, rb ? ra : {ra[15:1], 1'b0}, 16'($urandom));
            end else begin
                req_i = 1'b0;
            end
        end
        @(negedge clk_i);
        checkOutput("held_last_oneshot", done_o, 0);
        checkOutput("held_last_busy", busy_o, 0);

        $display("[TB] ack withheld");
        slave_rise = 1'b0;
        ack_en = 1'b0;
        driveFields(1'b0, 1'b0, 16'h0020, 16'h0000);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        checkOutput("noack_stb", stb_o, 1);
`ifdef XM_BUS_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 40);
        checkOutput("tmo_latency", 32'(n), 4);
        checkOutput("tmo_err", err_o, 1);
        checkOutput("tmo_cyc", cyc_o, 0);
        checkOutput("tmo_rdata", rdata_o, exp_rdata);
        @(negedge clk_i);
        checkOutput("tmo_idle", busy_o, 0);
        driveFields(1'b0, 1'b0, 16'h0020, 16'h0000);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
`else
        hi = 0;
        dn = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (stb_o) hi++;
            if (done_o) dn++;
        end
        checkOutput("noack_stb_held", 32'(hi), 100);
        checkOutput("noack_no_done", 32'(dn), 0);
`endif
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_cyc", cyc_o, 0);
        checkOutput("arst_stb", stb_o, 0);
        checkOutput("arst_busy", busy_o, 0);
        checkOutput("arst_rdata", rdata_o, 0);
        exp_rdata = 16'h0000;
        @(negedge clk_i);
        rst_i = 1'b0;
        ack_en = 1'b1;
        dn = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) dn++;
        end
        checkOutput("arst_no_done", 32'(dn), 0);
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("post_rst_load", rdata_o, 16'h5AEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
